// File: rtl/pulse_pair_gen.sv
// Pulse-pair generator: on Go, drives A high/low twice with programmable
// high and low lengths, then pulses Done for one cycle.
module pulse_pair_gen #(
  parameter int CNT_W = 8
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Go,
  input  logic             Abort,
  input  logic [CNT_W-1:0] HighLen,
  input  logic [CNT_W-1:0] LowLen,
  output logic             A,
  output logic             Busy,
  output logic             Done,
  output logic [2:0]       Phase
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    P1H  = 3'd1,
    P1L  = 3'd2,
    P2H  = 3'd3,
    P2L  = 3'd4
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_highLen;
  logic [CNT_W-1:0] r_lowLen;
  logic             r_a;
  logic             r_busy;
  logic             r_done;

  logic [CNT_W-1:0] w_goHighLoad;
  logic [CNT_W-1:0] w_highLoad;
  logic [CNT_W-1:0] w_lowLoad;
  logic             w_countZero;

  // Reload values are eff(x)-1, where a zero length behaves as one cycle.
  assign w_goHighLoad = (HighLen == '0)   ? '0 : HighLen - 1'b1;
  assign w_highLoad   = (r_highLen == '0) ? '0 : r_highLen - 1'b1;
  assign w_lowLoad    = (r_lowLen == '0)  ? '0 : r_lowLen - 1'b1;
  assign w_countZero  = (r_count == '0);

  assign A     = r_a;
  assign Busy  = r_busy;
  assign Done  = r_done;
  assign Phase = r_state;

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      r_state   <= IDLE;
      r_count   <= '0;
      r_highLen <= '0;
      r_lowLen  <= '0;
      r_a       <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (Abort) begin
        r_state <= IDLE;
        r_count <= '0;
        r_a     <= 1'b0;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            if (Go) begin
              r_state   <= P1H;
              r_highLen <= HighLen;
              r_lowLen  <= LowLen;
              r_count   <= w_goHighLoad;
              r_a       <= 1'b1;
              r_busy    <= 1'b1;
            end
          end
          P1H: begin
            if (w_countZero) begin
              r_state <= P1L;
              r_count <= w_lowLoad;
              r_a     <= 1'b0;
            end else begin
              r_count <= r_count - 1'b1;
            end
          end
          P1L: begin
            if (w_countZero) begin
              r_state <= P2H;
              r_count <= w_highLoad;
              r_a     <= 1'b1;
            end else begin
              r_count <= r_count - 1'b1;
            end
          end
          P2H: begin
            if (w_countZero) begin
              r_state <= P2L;
              r_count <= w_lowLoad;
              r_a     <= 1'b0;
            end else begin
              r_count <= r_count - 1'b1;
            end
          end
          P2L: begin
            if (w_countZero) begin
              r_state <= IDLE;
              r_a     <= 1'b0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_count <= r_count - 1'b1;
            end
          end
          // Unused encodings recover to a quiet idle.
          default: begin
            r_state <= IDLE;
            r_count <= '0;
            r_a     <= 1'b0;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pulse_pair_gen.sv
// Bench for pulse_pair_gen: timeline model of each transaction plus
// hand-computed per-cycle waveforms for the directed cases.
module tb_pulse_pair_gen;

  logic       Clock;
  logic       Reset;
  logic       Go;
  logic       Abort;
  logic [7:0] HighLen;
  logic [7:0] LowLen;
  logic       A;
  logic       Busy;
  logic       Done;
  logic [2:0] Phase;

  int compared;
  int mismatched;
  bit checkEn;
  int phLog[64];

  pulse_pair_gen #(.CNT_W(8)) dut (
    .Clock(Clock), .Reset(Reset), .Go(Go), .Abort(Abort),
    .HighLen(HighLen), .LowLen(LowLen),
    .A(A), .Busy(Busy), .Done(Done), .Phase(Phase)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  // Model: remembers when Go was accepted and derives outputs from the
  // cycle offset within the 2H+2L+1 transaction timeline.
  int  edgeNum;
  int  t0;
  int  mH;
  int  mL;
  int  kOff;
  bit  active;
  logic expA;
  logic expBusy;
  logic expDone;
  int  expPhase;

  function automatic int eff(input int x);
    return (x == 0) ? 1 : x;
  endfunction

  initial begin
    edgeNum = 0;
    active  = 1'b0;
    t0 = 0; mH = 1; mL = 1; kOff = 0;
    expA = 1'b0; expBusy = 1'b0; expDone = 1'b0; expPhase = 0;
  end

  always @(posedge Clock) begin
    expA = 1'b0; expBusy = 1'b0; expDone = 1'b0; expPhase = 0;
    if (!Reset || Abort) begin
      active = 1'b0;
    end else begin
      if (!active && Go) begin
        active = 1'b1;
        t0     = edgeNum;
        mH     = eff(int'(HighLen));
        mL     = eff(int'(LowLen));
      end
      if (active) begin
        kOff = edgeNum - t0 + 1;
        if (kOff > 2*mH + 2*mL) begin
          expDone = 1'b1;
          active  = 1'b0;
        end else begin
          expBusy  = 1'b1;
          expA     = (kOff <= mH) || (kOff > mH + mL && kOff <= 2*mH + mL);
          expPhase = (kOff <= mH) ? 1 : (kOff <= mH + mL) ? 2 :
                     (kOff <= 2*mH + mL) ? 3 : 4;
        end
      end
    end
    edgeNum++;
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    compared++;
    if (actual != expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge Clock) begin
    if (checkEn) begin
      checkOutput("mdlA", int'(A), int'(expA));
      checkOutput("mdlBusy", int'(Busy), int'(expBusy));
      checkOutput("mdlDone", int'(Done), int'(expDone));
      checkOutput("mdlPhase", int'(Phase), expPhase);
      checkOutput("busyDoneExcl", int'(Busy && Done), 0);
    end
  end

  // Called at a negedge in an idle cycle; Go is sampled at the next edge.
  // Bit k of pA/pB/pD is the required A/Busy/Done in cycle k.
  task automatic applyStimulus(input string name, input int h, input int l, input int n,
                               input bit holdGo, input int regoAt, input int abortAt,
                               input int resetAt, input logic [31:0] pA,
                               input logic [31:0] pB, input logic [31:0] pD);
    HighLen = 8'(h);
    LowLen  = 8'(l);
    Go      = 1'b1;
    for (int k = 1; k <= n; k++) begin
      @(negedge Clock);
      checkOutput({name, "_A"}, int'(A), int'(pA[k]));
      checkOutput({name, "_Busy"}, int'(Busy), int'(pB[k]));
      checkOutput({name, "_Done"}, int'(Done), int'(pD[k]));
      phLog[k] = int'(Phase);
      Go    = (holdGo && k < n) || (k == regoAt) || (k == resetAt);
      Abort = (k == abortAt);
      Reset = !(k == resetAt);
      if (k == regoAt) HighLen = 8'd7;
    end
    Go    = 1'b0;
    Abort = 1'b0;
    Reset = 1'b1;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) @(negedge Clock);
  endtask

  int doneAt;
  int basicPh[11] = '{1, 1, 1, 2, 2, 3, 3, 3, 4, 4, 0};

  initial begin
    compared = 0; mismatched = 0; checkEn = 1'b0;
    Reset = 1'b0; Go = 1'b0; Abort = 1'b0; HighLen = '0; LowLen = '0;

    @(negedge Clock);
    checkEn = 1'b1;
    for (int i = 0; i < 2; i++) begin
      checkOutput("rstA", int'(A), 0);
      checkOutput("rstBusy", int'(Busy), 0);
      checkOutput("rstDone", int'(Done), 0);
      checkOutput("rstPhase", int'(Phase), 0);
      if (i == 0) @(negedge Clock);
    end
    Reset = 1'b1;
    idleCycles(2);

    $display("[TB] basic H=3 L=2");
    applyStimulus("basic", 3, 2, 12, 1'b0, -1, -1, -1, 32'h1CE, 32'h7FE, 32'h800);
    for (int k = 1; k <= 11; k++) checkOutput("basicPhase", phLog[k], basicPh[k-1]);
    idleCycles(2);

    $display("[TB] zero lengths");
    applyStimulus("zero", 0, 0, 6, 1'b0, -1, -1, -1, 32'h00A, 32'h01E, 32'h020);
    idleCycles(2);

    $display("[TB] max lengths");
    HighLen = 8'd255; LowLen = 8'd255; Go = 1'b1;
    doneAt = -1;
    for (int k = 1; k <= 1100 && doneAt < 0; k++) begin
      @(negedge Clock);
      Go = 1'b0;
      if (Done) doneAt = k;
    end
    checkOutput("maxDoneCycle", doneAt, 1021);
    idleCycles(2);

    $display("[TB] Go while busy with HighLen change");
    applyStimulus("rego", 3, 2, 14, 1'b0, 4, -1, -1, 32'h1CE, 32'h7FE, 32'h800);
    idleCycles(2);

    $display("[TB] back-to-back H=L=1");
    applyStimulus("b2b", 1, 1, 15, 1'b1, -1, -1, -1, 32'h294A, 32'h7BDE, 32'h8420);
    idleCycles(2);

    $display("[TB] abort in P2H");
    applyStimulus("abort", 3, 2, 12, 1'b0, -1, 7, -1, 32'h0CE, 32'h0FE, 32'h000);
    applyStimulus("postAbort", 3, 2, 12, 1'b0, -1, -1, -1, 32'h1CE, 32'h7FE, 32'h800);
    idleCycles(2);

    $display("[TB] reset mid-transaction");
    applyStimulus("midReset", 3, 2, 10, 1'b0, -1, -1, 5, 32'h00E, 32'h03E, 32'h000);
    applyStimulus("postReset", 2, 2, 10, 1'b0, -1, -1, -1, 32'h066, 32'h1FE, 32'h200);
    idleCycles(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/pulse_pair_gen.md
# pulse_pair_gen

Pulse-pair generator that drives the `A` line consumed by the Idle/Start/Stop/Clear pulse-detect FSM. On a `Go` request it emits two high pulses on `A`, each followed by a low gap, with programmable high and low durations: rise, fall, rise, fall. The receiver sees exactly one full Idle→Start→Stop→Clear→Idle walk. It sits in the stimulus/control path upstream of that FSM and reports `Busy` and `Done` to the sequencing logic.

## Interface
- `CNT_W`, default 8: width of the duration fields and of the internal down-counter.
- `Clock`, input, 1: clock; all state changes on the rising edge.
- `Reset`, input, 1: reset, synchronous, active-low.
- `Go`, input, 1: start request; sampled only in Idle.
- `Abort`, input, 1: synchronous abort; returns the block to Idle.
- `HighLen`, input, CNT_W: high-phase length in cycles; latched when `Go` is accepted.
- `LowLen`, input, CNT_W: low-phase length in cycles; latched when `Go` is accepted.
- `A`, output, 1: generated line; registered.
- `Busy`, output, 1: high in every non-Idle state.
- `Done`, output, 1: one-cycle pulse on normal completion.
- `Phase`, output, 3: current state encoding, for debug and verification.

## Operation
- States and `Phase` encodings:
  - IDLE = 3'd0
  - P1H = 3'd1
  - P1L = 3'd2
  - P2H = 3'd3
  - P2L = 3'd4
  - Codes 5–7 are illegal; they go to IDLE on the next edge with `A`=0.
- `A`=1 exactly in P1H and P2H, and 0 in all other states. It is a registered flop, not a decode of `Phase`, so it is glitch-free.
- `Busy` = (state != IDLE), registered.
- Go acceptance: in IDLE with `Go`=1 and `Abort`=0, the block latches `HighLen` and `LowLen`, loads the counter with eff(HighLen)−1, and moves to P1H.
- Length rule: eff(x) = (x==0) ? 1 : x. Zero lengths are treated as 1. There is no overflow because the counter loads at most 2^CNT_W−1.
- Phase advance: each non-IDLE state decrements the counter. When counter==0, the state advances and the counter reloads:
  - P1H→P1L, load eff(LowLen)−1.
  - P1L→P2H, load eff(HighLen)−1.
  - P2H→P2L, load eff(LowLen)−1.
  - P2L→IDLE, with `Done`=1 for that one cycle.
- `Go` while `Busy`: ignored, not queued. `HighLen`/`LowLen` changes while `Busy` have no effect.
- `Abort`=1 in any state: next edge gives IDLE, `A`=0, `Busy`=0, `Done`=0, counter cleared. `Abort` has priority over `Go` and over a phase advance.
- `Reset`=0: has priority over everything. Next edge gives IDLE, `A`=0, `Busy`=0, `Done`=0, `Phase`=0, counter and latched lengths = 0. This applies identically mid-transaction.
- Back-to-back: `Go` asserted during the `Done` cycle (state is IDLE) is accepted, so a new P1H starts the following cycle.

## Timing
- `Go` is sampled at edge 0. Then:
  - `A`=1 during cycles 1..H.
  - `A`=0 during H+1..H+L.
  - `A`=1 during H+L+1..2H+L.
  - `A`=0 during 2H+L+1..2H+2L.
  - `Done`=1 in cycle 2H+2L+1.
  - Here H and L are the effective lengths.
- Latency from `Go` to the first rising edge of `A` is 1 cycle.
- Minimum spacing between accepted `Go`s is 2H+2L+1 cycles.
- `Done` and `Busy` are never high in the same cycle.
- Downstream K2 (Stop→Clear) follows the second rise and K1 (Clear→Idle) follows the second fall. Each `Go` produces exactly one K1.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Basic: Reset low 2 cycles, then `Go` with H=3, L=2 → `A` high cycles 1–3, low 4–5, high 6–8, low 9–10; `Done` in cycle 11; `Busy` 1–10; `Phase` sequence 1,2,3,4,0.
- Zero lengths: H=0, L=0 → `A`=1,0,1,0 in cycles 1–4; `Done` in cycle 5. Max lengths: H=L=255 → `Done` in cycle 1021.
- `Go` pulsed at cycle 4 of a H=3, L=2 run, with `HighLen` changed to 7 → waveform unchanged from the basic case; no second transaction.
- Back-to-back: `Go` held high continuously with H=L=1 → `A` pattern 1010 then 0 (`Done`) repeating with period 5; second rise in cycle 6.
- `Abort` in cycle 7 of the basic case (P2H) → `A`=0, `Phase`=0, `Busy`=0 from cycle 8; `Done` never asserts; next `Go` runs a full clean transaction.
- `Reset`=0 in cycle 5 of the basic case → all outputs 0 from cycle 6; `Go` held during reset is ignored; after release, a `Go` with H=2, L=2 gives `Done` 9 cycles after acceptance.
